// File: rtl/pe_seq_ctrl.sv
// Convolution PE sequencer: issues per-tap scratchpad reads, steers the PE
// mult/acc selects through a pipeline-matched delay line, and hands off psums.
module pe_seq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned PIPE_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_num_out,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] ifmap_addr,
  output logic [ADDR_WIDTH-1:0] fltr_addr,
  output logic                  mult_seln,
  output logic                  acc_seln,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DRAIN_WIDTH = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    DRAIN  = 3'd2,
    OUTPUT = 3'd3,
    FIN    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   tap_q, tap_d;
  logic [CNT_WIDTH-1:0]   win_q, win_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [DRAIN_WIDTH-1:0] drain_q, drain_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [ADDR_WIDTH-1:0]  stride_q, stride_d;

  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] ifmap_addr_q, ifmap_addr_d;
  logic [ADDR_WIDTH-1:0] fltr_addr_q, fltr_addr_d;
  logic                  first_q, first_d;
  logic                  psum_valid_q, psum_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PIPE_LAT-1:0]   mult_dl_q;
  logic [PIPE_LAT-1:0]   acc_dl_q;

  // State, counters, latched config, registered outputs and PE delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      win_q        <= '0;
      base_q       <= '0;
      drain_q      <= '0;
      len_q        <= '0;
      num_q        <= '0;
      stride_q     <= '0;
      rd_en_q      <= 1'b0;
      ifmap_addr_q <= '0;
      fltr_addr_q  <= '0;
      first_q      <= 1'b0;
      psum_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mult_dl_q    <= '0;
      acc_dl_q     <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      win_q        <= win_d;
      base_q       <= base_d;
      drain_q      <= drain_d;
      len_q        <= len_d;
      num_q        <= num_d;
      stride_q     <= stride_d;
      rd_en_q      <= rd_en_d;
      ifmap_addr_q <= ifmap_addr_d;
      fltr_addr_q  <= fltr_addr_d;
      first_q      <= first_d;
      psum_valid_q <= psum_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mult_dl_q    <= PIPE_LAT'({mult_dl_q, rd_en_q});
      acc_dl_q     <= PIPE_LAT'({acc_dl_q, first_q});
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    win_d    = win_q;
    base_d   = base_q;
    drain_d  = drain_q;
    len_d    = len_q;
    num_d    = num_q;
    stride_d = stride_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = cfg_len;
          num_d    = cfg_num_out;
          stride_d = cfg_stride;
          tap_d    = '0;
          win_d    = '0;
          base_d   = '0;
          if (cfg_len == '0 || cfg_num_out == '0) state_d = FIN;
          else                                    state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tap_q == len_q - LEN_WIDTH'(1)) begin
          state_d = DRAIN;
          drain_d = DRAIN_WIDTH'(PIPE_LAT);
        end else begin
          tap_d = tap_q + LEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_WIDTH'(1)) state_d = OUTPUT;
        else                            drain_d = drain_q - DRAIN_WIDTH'(1);
      end
      OUTPUT: begin
        if (psum_ready) begin
          if (win_q == num_q - CNT_WIDTH'(1)) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            base_d  = base_q + stride_q;
            tap_d   = '0;
            win_d   = win_q + CNT_WIDTH'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    rd_en_d      = (state_d == ISSUE);
    ifmap_addr_d = '0;
    fltr_addr_d  = '0;
    first_d      = 1'b0;
    if (rd_en_d) begin
      ifmap_addr_d = base_d + ADDR_WIDTH'(tap_d);
      fltr_addr_d  = ADDR_WIDTH'(tap_d);
      first_d      = (tap_d == '0);
    end
    psum_valid_d = (state_d == OUTPUT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

  assign rd_en      = rd_en_q;
  assign ifmap_addr = ifmap_addr_q;
  assign fltr_addr  = fltr_addr_q;
  assign mult_seln  = mult_dl_q[PIPE_LAT-1];
  assign acc_seln   = acc_dl_q[PIPE_LAT-1];
  assign psum_valid = psum_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: per-cycle traces of each job are packed into
// bitmasks / address strings and compared to hand-derived values.
module tb_pe_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] cfg_len;
  logic [7:0] cfg_num_out;
  logic [3:0] cfg_stride;
  logic       rd_en;
  logic [3:0] ifmap_addr;
  logic [3:0] fltr_addr;
  logic       mult_seln;
  logic       acc_seln;
  logic       psum_valid;
  logic       psum_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] rd_m, mult_m, acc_m, pv_m, busy_m, done_m, if_seq, fl_seq;
  int          hs_cnt;

  pe_seq_ctrl #(
    .ADDR_WIDTH(4), .LEN_WIDTH(5), .CNT_WIDTH(8), .PIPE_LAT(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_num_out(cfg_num_out),
    .cfg_stride (cfg_stride),
    .rd_en      (rd_en),
    .ifmap_addr (ifmap_addr),
    .fltr_addr  (fltr_addr),
    .mult_seln  (mult_seln),
    .acc_seln   (acc_seln),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rd_en, ifmap_addr, fltr_addr, mult_seln, acc_seln, psum_valid, busy, done});
  endfunction

  // Entered at a sample point (#1 after posedge) = cycle 0; records 40 cycles.
  // From cycle 1 on, cfg_* hold a different config to show it is ignored.
  task automatic run_job(input logic [4:0] len, input logic [7:0] num, input logic [3:0] stride,
                         input int ready_cyc, input int s2_cyc);
    rd_m = '0; mult_m = '0; acc_m = '0; pv_m = '0; busy_m = '0; done_m = '0;
    if_seq = '0; fl_seq = '0; hs_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      start      = (k == 0) || (k == s2_cyc);
      psum_ready = (k >= ready_cyc);
      if (k == 0) begin
        cfg_len = len; cfg_num_out = num; cfg_stride = stride;
      end else begin
        cfg_len = 5'd5; cfg_num_out = 8'd4; cfg_stride = 4'd3;
      end
      rd_m[k]   = rd_en;
      mult_m[k] = mult_seln;
      acc_m[k]  = acc_seln;
      pv_m[k]   = psum_valid;
      busy_m[k] = busy;
      done_m[k] = done;
      if (rd_en) begin
        if_seq = {if_seq[59:0], ifmap_addr};
        fl_seq = {fl_seq[59:0], fltr_addr};
      end
      if (psum_valid && psum_ready) hs_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; psum_ready = 1'b0;
    cfg_len = '0; cfg_num_out = '0; cfg_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", all_outs(), 64'h0);

    // Basic single window
    run_job(5'd3, 8'd1, 4'd1, 0, 999);
    check("basic_rd",    rd_m,   64'h0E);
    check("basic_mult",  mult_m, 64'h70);
    check("basic_acc",   acc_m,  64'h10);
    check("basic_pv",    pv_m,   64'h80);
    check("basic_done",  done_m, 64'h100);
    check("basic_busy",  busy_m, 64'h1FE);
    check("basic_ifmap", if_seq, 64'h012);
    check("basic_fltr",  fl_seq, 64'h012);

    // Sliding windows, stride 2
    run_job(5'd3, 8'd3, 4'd2, 0, 999);
    check("slide_rd",    rd_m,   64'h3870E);
    check("slide_mult",  mult_m, 64'h1C3870);
    check("slide_acc",   acc_m,  64'h40810);
    check("slide_pv",    pv_m,   64'h204080);
    check("slide_done",  done_m, 64'h400000);
    check("slide_ifmap", if_seq, 64'h012234456);
    check("slide_fltr",  fl_seq, 64'h012012012);
    check("slide_hs",    64'(hs_cnt), 64'd3);

    // Backpressure: ready only from cycle 12
    run_job(5'd3, 8'd1, 4'd1, 12, 999);
    check("bp_pv",   pv_m,   64'h1F80);
    check("bp_done", done_m, 64'h2000);
    check("bp_rd",   rd_m,   64'h0E);
    check("bp_busy", busy_m, 64'h3FFE);

    // Address wrap
    run_job(5'd4, 8'd2, 4'd14, 0, 999);
    check("wrap_ifmap", if_seq, 64'h0123EF01);
    check("wrap_fltr",  fl_seq, 64'h01230123);
    check("wrap_done",  done_m, 64'h20000);
    check("wrap_hs",    64'(hs_cnt), 64'd2);

    // Degenerate configs
    run_job(5'd0, 8'd2, 4'd1, 0, 999);
    check("len0_done", done_m, 64'h2);
    check("len0_busy", busy_m, 64'h2);
    check("len0_rd",   rd_m,   64'h0);
    run_job(5'd3, 8'd0, 4'd1, 0, 999);
    check("num0_done", done_m, 64'h2);
    check("num0_rd",   rd_m,   64'h0);

    // Start during DRAIN with another config is ignored
    run_job(5'd3, 8'd2, 4'd1, 0, 5);
    check("sbusy_ifmap", if_seq, 64'h012123);
    check("sbusy_hs",    64'(hs_cnt), 64'd2);
    check("sbusy_done",  done_m, 64'h8000);
    check("sbusy_busy",  busy_m, 64'hFFFE);

    // Asynchronous reset mid-ISSUE
    start = 1'b1; cfg_len = 5'd8; cfg_num_out = 8'd1; cfg_stride = 4'd1; psum_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort_pre", 64'({rd_en, mult_seln, busy}), 64'h7);
    #2 rst = 1'b1;
    #1;
    check("abort_outs", all_outs(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(5'd3, 8'd1, 4'd1, 0, 999);
    check("post_rst_ifmap", if_seq, 64'h012);
    check("post_rst_acc",   acc_m,  64'h10);
    check("post_rst_done",  done_m, 64'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
Sequencer for a single convolution PE. It drives the ifmap and filter scratchpad read addresses and the PE's mult_seln/acc_seln controls. For each output window it accumulates cfg_len taps, then presents the finished partial sum through a valid/ready handshake. It handles cfg_num_out sliding windows per start, advancing the ifmap base by cfg_stride between windows.

Parameters:
ADDR_WIDTH, 4, scratchpad address width (ifmap and filter).
LEN_WIDTH, 5, width of cfg_len (0..2^LEN_WIDTH-1 taps).
CNT_WIDTH, 8, width of cfg_num_out.
PIPE_LAT, 3, cycles from scratchpad read issue until that product reaches the PE accumulator adder (scratchpad read 1 + multiplier 2). Must be >= 1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a job; sampled only in IDLE
cfg_len  input  LEN_WIDTH  taps per window
cfg_num_out  input  CNT_WIDTH  number of windows (psums) in the job
cfg_stride  input  ADDR_WIDTH  ifmap base increment per window
rd_en  output  1  scratchpad read strobe
ifmap_addr  output  ADDR_WIDTH  ifmap read address
fltr_addr  output  ADDR_WIDTH  filter read address
mult_seln  output  1  1 = PE accumulates the multiplier result this cycle
acc_seln  output  1  1 = PE clears the accumulator feedback (first tap of a window)
psum_valid  output  1  PE psum output holds a completed window sum
psum_ready  input  1  downstream accepts the psum
busy  output  1  job in progress
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (asynchronous, any time, including mid-job): state IDLE, all counters 0, delay line cleared, and every output 0. The first cycle after reset deassertion is IDLE.
- Config is latched on the cycle start is accepted. Changes to cfg_* during a job are ignored. start is ignored while busy.
- States:
  - IDLE: on start, if cfg_len==0 or cfg_num_out==0, go to FIN. Otherwise go to ISSUE with tap=0, win=0, base=0.
  - ISSUE: one cycle per tap.
    - rd_en=1, ifmap_addr=base+tap (mod 2^ADDR_WIDTH), fltr_addr=tap.
    - On tap==cfg_len-1, go to DRAIN with drain counter = PIPE_LAT.
  - DRAIN: exactly PIPE_LAT cycles with rd_en=0, then go to OUTPUT.
  - OUTPUT: psum_valid=1, held until psum_ready=1 in the same cycle (handshake). On handshake:
    - win+1==cfg_num_out: go to FIN.
    - Otherwise: base+=cfg_stride (wraps), tap=0, win+=1, go to ISSUE.
    - psum_valid may already be 1 on the same cycle OUTPUT is entered; psum_ready asserted early has no effect outside OUTPUT.
  - FIN: done=1 for one cycle, then IDLE.
- When idle, rd_en, ifmap_addr and fltr_addr are 0.
- busy is 1 in ISSUE, DRAIN, OUTPUT and FIN, and 0 in IDLE.
- PE control timing uses a PIPE_LAT-deep delay line of {rd_en, first_tap}:
  - mult_seln = rd_en delayed PIPE_LAT cycles.
  - acc_seln = (rd_en AND tap==0) delayed PIPE_LAT cycles.
  - Hence acc_seln is 1 only together with mult_seln on a window's first product.
  - All outputs are registered.
- Latency: a window of L taps issued starting at cycle c presents psum_valid at cycle c+L+PIPE_LAT. No bubbles occur between ISSUE cycles within a window.
- Next window's first read issues the cycle after the psum handshake; windows never overlap in the PE.

Test Plan:
- Basic: PIPE_LAT=3; start at cycle 0 with len=3, num_out=1, stride=1; psum_ready=1 → rd_en cycles 1-3, addr 0,1,2; mult_seln cycles 4-6; acc_seln cycle 4 only; psum_valid cycle 7; done cycle 8; busy cycles 1-8.
- Sliding windows: len=3, num_out=3, stride=2 → ifmap_addr 0,1,2 / 2,3,4 / 4,5,6; fltr_addr 0,1,2 each window; three psum handshakes; acc_seln exactly once per window.
- Backpressure: same as basic, psum_ready low until cycle 12 → psum_valid stays 1 cycles 7-12; done cycle 13; no rd_en during the stall.
- Address wrap: ADDR_WIDTH=4, len=4, num_out=2, stride=14 → second window ifmap_addr 14,15,0,1.
- Degenerate and abort: len=0 → done on the cycle after start, rd_en never set. Separately, rst asserted mid-ISSUE → all outputs 0 immediately. A new start after reset runs from addr 0.
- Start ignored while busy: pulse start during DRAIN with different cfg → job continues with the original config; exactly num_out psums are produced.
